// File: rtl/mmu_asid.sv
// mmu_asid: ASID-tagged, fully associative TLB with a two-level page walker.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   suspend             aborts any walk or flush; TLB contents are kept
//   en_mmu, asid        translation enable and current address-space id
//   pdb_addr, logical   page directory base and logical page number ([31:12])
//   stall               MMU busy; the requester holds its inputs while high
//   physical, page_fault, auth_user, auth_exec, auth_write, en_cache
//                       translation result (pass-through when not translating)
//   flush_req/flush_mode/flush_ack  TLB invalidate handshake
//   ren/addr/ack/data   page-table read port
//   fsm_state           debug view of the walker state (IDLE/PDE/PTE/FLUSH = 0..3)
//
// Handshakes: ren is a level request held with a stable addr until the
// one-cycle ack returns data; flush_req is a level request held until
// flush_ack pulses for exactly one cycle, in the cycle the flush happens.
module mmu_asid #(
    parameter int LINE_NUM  = 16,
    parameter int ASID_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 suspend,
    input  logic                 en_mmu,
    input  logic [ASID_BITS-1:0] asid,
    input  logic [19:0]          pdb_addr,
    input  logic [19:0]          logical,
    output logic                 stall,
    output logic [19:0]          physical,
    output logic                 page_fault,
    output logic                 auth_user,
    output logic                 auth_exec,
    output logic                 auth_write,
    output logic                 en_cache,
    input  logic                 flush_req,
    input  logic [1:0]           flush_mode,
    output logic                 flush_ack,
    output logic                 ren,
    output logic [31:0]          addr,
    input  logic                 ack,
    input  logic [31:0]          data,
    output logic [1:0]           fsm_state
);
    localparam int IDX_BITS = $clog2(LINE_NUM);

    typedef enum logic [1:0] {IDLE = 2'd0, PDE = 2'd1, PTE = 2'd2, FLUSH = 2'd3} state_t;
    state_t state, state_next;

    // TLB lines; attr = {cache, exec, write, user, present}
    logic [LINE_NUM-1:0]  line_valid;
    logic [LINE_NUM-1:0]  line_global;
    logic [ASID_BITS-1:0] line_asid [LINE_NUM];
    logic [19:0]          line_tag  [LINE_NUM];
    logic [19:0]          line_ppn  [LINE_NUM];
    logic [4:0]           line_attr [LINE_NUM];
    logic [IDX_BITS-1:0]  rr_ptr;
    logic [4:0]           attr_buf;

    logic                hit;
    logic [IDX_BITS-1:0] hit_idx;
    logic                has_free;
    logic [IDX_BITS-1:0] free_idx;
    logic [IDX_BITS-1:0] victim;
    logic [LINE_NUM-1:0] flush_match;

    logic        start_walk;
    logic        pde_next;
    logic        install;
    logic        flush_now;
    logic [4:0]  fill_attr;
    logic        fill_global;
    logic        translate;

    // Only the PPN, the global bit and the attribute bits of an entry are used.
    logic unused_data_bits;
    assign unused_data_bits = ^data[11:6];

    // Lookup, free-line search and flush match. Scanning from the top down
    // lets the lowest-index free line win.
    always_comb begin
        hit         = 1'b0;
        hit_idx     = '0;
        has_free    = 1'b0;
        free_idx    = '0;
        flush_match = '0;
        for (int i = LINE_NUM - 1; i >= 0; i--) begin
            if (line_valid[i] && line_tag[i] == logical &&
                (line_global[i] || line_asid[i] == asid)) begin
                hit     = 1'b1;
                hit_idx = IDX_BITS'(i);
            end
            if (!line_valid[i]) begin
                has_free = 1'b1;
                free_idx = IDX_BITS'(i);
            end
            case (flush_mode)
                2'd1:    flush_match[i] = (line_asid[i] == asid) && !line_global[i];
                2'd2:    flush_match[i] = (line_tag[i] == logical);
                default: flush_match[i] = 1'b1;   // mode 0 and reserved mode 3
            endcase
        end
    end

    assign victim = has_free ? free_idx : rr_ptr;

    // Next-state and walk control
    always_comb begin
        state_next  = state;
        start_walk  = 1'b0;
        pde_next    = 1'b0;
        install     = 1'b0;
        fill_attr   = data[4:0];
        fill_global = 1'b0;
        case (state)
            IDLE: begin
                if (flush_req) begin
                    state_next = FLUSH;
                end else if (en_mmu && !hit) begin
                    state_next = PDE;
                    start_walk = 1'b1;
                end
            end
            PDE: begin
                if (ack) begin
                    if (data[0]) begin
                        state_next = PTE;
                        pde_next   = 1'b1;
                    end else begin
                        // Non-present directory entry is cached as-is so the
                        // retried access reports the fault from the TLB.
                        install    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            PTE: begin
                if (ack) begin
                    install     = 1'b1;
                    fill_attr   = data[4:0] & attr_buf;
                    fill_global = data[5];
                    state_next  = IDLE;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (suspend) begin
            state_next = IDLE;
            start_walk = 1'b0;
            pde_next   = 1'b0;
            install    = 1'b0;
        end
    end

    assign flush_now = (state == FLUSH) && !suspend;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Page-table read port
    always_ff @(posedge clk) begin
        if (rst || suspend) begin
            ren  <= 1'b0;
            addr <= '0;
        end else if (start_walk) begin
            ren  <= 1'b1;
            addr <= {pdb_addr, logical[19:10], 2'b00};
        end else if (pde_next) begin
            addr <= {data[31:12], logical[9:0], 2'b00};
        end else if (install) begin
            ren  <= 1'b0;
        end
    end

    // Valid bits, replacement pointer and directory attribute buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid <= '0;
            rr_ptr     <= '0;
            attr_buf   <= 5'b01111;
        end else begin
            if (pde_next) attr_buf <= data[4:0];
            if (flush_now) line_valid <= line_valid & ~flush_match;
            if (install) begin
                line_valid[victim] <= 1'b1;
                if (!has_free) rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

    // Line payload needs no reset: it is only read through a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && install) begin
            line_global[victim] <= fill_global;
            line_asid[victim]   <= asid;
            line_tag[victim]    <= logical;
            line_ppn[victim]    <= data[31:12];
            line_attr[victim]   <= fill_attr;
        end
    end

    assign stall     = (state != IDLE) || (en_mmu && (flush_req || !hit));
    assign flush_ack = flush_now && !rst;
    assign fsm_state = state;

    // When translate is high the lookup necessarily hit, else stall would be set.
    assign translate = en_mmu && !stall;

    always_comb begin
        physical   = logical;
        page_fault = 1'b0;
        auth_user  = 1'b1;
        auth_exec  = 1'b1;
        auth_write = 1'b1;
        en_cache   = 1'b0;
        if (translate) begin
            physical   = line_ppn[hit_idx];
            page_fault = ~line_attr[hit_idx][0];
            auth_user  = line_attr[hit_idx][1];
            auth_write = line_attr[hit_idx][2];
            auth_exec  = line_attr[hit_idx][3];
            en_cache   = line_attr[hit_idx][4];
        end
    end

endmodule

// File: tb/tb_mmu_asid.sv
// tb_mmu_asid: randomized and directed checks of mmu_asid against a
// behavioural TLB/page-table model held in the bench.
module tb_mmu_asid;
    localparam int LINE_NUM  = 16;
    localparam int ASID_BITS = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 suspend;
    logic                 en_mmu;
    logic [ASID_BITS-1:0] asid;
    logic [19:0]          pdb_addr;
    logic [19:0]          logical;
    logic                 stall;
    logic [19:0]          physical;
    logic                 page_fault, auth_user, auth_exec, auth_write, en_cache;
    logic                 flush_req;
    logic [1:0]           flush_mode;
    logic                 flush_ack;
    logic                 ren;
    logic [31:0]          addr;
    logic                 ack;
    logic [31:0]          data;
    logic [1:0]           fsm_state;

    int errors = 0;
    int checks = 0;

    mmu_asid #(.LINE_NUM(LINE_NUM), .ASID_BITS(ASID_BITS)) dut (
        .clk(clk), .rst(rst), .suspend(suspend), .en_mmu(en_mmu), .asid(asid),
        .pdb_addr(pdb_addr), .logical(logical), .stall(stall), .physical(physical),
        .page_fault(page_fault), .auth_user(auth_user), .auth_exec(auth_exec),
        .auth_write(auth_write), .en_cache(en_cache), .flush_req(flush_req),
        .flush_mode(flush_mode), .flush_ack(flush_ack), .ren(ren), .addr(addr),
        .ack(ack), .data(data), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // ---------------- page-table memory ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] h;
        if (mem.exists(a)) return mem[a];
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        return h;
    endfunction

    // ---------------- reference model ----------------
    logic                 m_valid  [LINE_NUM];
    logic                 m_global [LINE_NUM];
    logic [ASID_BITS-1:0] m_asid   [LINE_NUM];
    logic [19:0]          m_tag    [LINE_NUM];
    logic [19:0]          m_ppn    [LINE_NUM];
    logic [4:0]           m_attr   [LINE_NUM];
    int                   m_rr;
    logic [31:0]          exp_q [$];   // expected page-table read addresses

    function automatic int model_find(input logic [19:0] lg, input logic [ASID_BITS-1:0] as);
        for (int i = 0; i < LINE_NUM; i++)
            if (m_valid[i] && m_tag[i] == lg && (m_global[i] || m_asid[i] == as)) return i;
        return -1;
    endfunction

    function automatic void model_install(input logic [19:0] lg, input logic [ASID_BITS-1:0] as,
                                          input logic [19:0] ppn, input logic [4:0] attr,
                                          input logic glob);
        int v = -1;
        for (int i = 0; i < LINE_NUM; i++)
            if (!m_valid[i] && v < 0) v = i;
        if (v < 0) begin
            v = m_rr;
            m_rr = (m_rr + 1) % LINE_NUM;
        end
        m_valid[v] = 1'b1; m_global[v] = glob; m_asid[v] = as;
        m_tag[v] = lg; m_ppn[v] = ppn; m_attr[v] = attr;
    endfunction

    function automatic void model_flush(input logic [1:0] mode, input logic [19:0] lg,
                                        input logic [ASID_BITS-1:0] as);
        for (int i = 0; i < LINE_NUM; i++) begin
            if (mode == 2'd1) begin
                if (m_asid[i] == as && !m_global[i]) m_valid[i] = 1'b0;
            end else if (mode == 2'd2) begin
                if (m_tag[i] == lg) m_valid[i] = 1'b0;
            end else begin
                m_valid[i] = 1'b0;
            end
        end
    endfunction

    // Two-level walk straight from the page-table rules; queues the read addresses.
    function automatic void model_walk(input logic [19:0] lg, output logic [19:0] ppn,
                                       output logic [4:0] attr, output logic glob,
                                       output int nreads);
        logic [31:0] pde_a, pte_a, pde, pte;
        pde_a = {pdb_addr, lg[19:10], 2'b00};
        pde   = mem_read(pde_a);
        exp_q.push_back(pde_a);
        if (!pde[0]) begin
            ppn = pde[31:12]; attr = pde[4:0]; glob = 1'b0; nreads = 1;
        end else begin
            pte_a = {pde[31:12], lg[9:0], 2'b00};
            pte   = mem_read(pte_a);
            exp_q.push_back(pte_a);
            ppn = pte[31:12]; attr = pte[4:0] & pde[4:0]; glob = pte[5]; nreads = 2;
        end
    endfunction

    function automatic logic [24:0] pack_exp(input logic [19:0] ppn, input logic [4:0] attr);
        return {ppn, ~attr[0], attr[1], attr[3], attr[2], attr[4]};
    endfunction

    function automatic logic [24:0] pack_obs();
        return {physical, page_fault, auth_user, auth_exec, auth_write, en_cache};
    endfunction

    // ---------------- page-table responder ----------------
    int          cyc = 0;
    int          ack_count = 0;
    int          last_ack_cyc = -10;
    int          ack_allow = -1;     // -1 unlimited, otherwise acks still permitted
    int          wait_cnt = 0;
    logic [31:0] rd_log [$];

    initial begin
        ack  = 1'b0;
        data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            ack = 1'b0;
            if (ren && ack_allow != 0) begin
                if (wait_cnt == 0) begin
                    check_val("rd_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check_val("rd_addr", addr, exp_q.pop_front());
                    ack  = 1'b1;
                    data = mem_read(addr);
                    rd_log.push_back(addr);
                    ack_count++;
                    last_ack_cyc = cyc;
                    wait_cnt = $urandom_range(0, 2);
                    if (ack_allow > 0) ack_allow--;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_access(input string tag, input logic [19:0] lg, input logic [ASID_BITS-1:0] as);
        int          idx, nreads, budget, reads0;
        logic [19:0] ppn;
        logic [4:0]  attr;
        logic        glob;
        @(negedge clk); #1;
        idx = model_find(lg, as);
        if (idx < 0) begin
            model_walk(lg, ppn, attr, glob, nreads);
        end else begin
            ppn = m_ppn[idx]; attr = m_attr[idx]; glob = m_global[idx]; nreads = 0;
        end
        reads0    = ack_count;
        logical   = lg;
        asid      = as;
        flush_req = 1'b0;
        en_mmu    = 1'b1;
        #1;
        check_val({tag, "_stall0"}, 32'(stall), 32'(idx < 0));
        budget = 0;
        while (stall && budget < 60) begin
            @(negedge clk); #1;
            budget++;
        end
        check_val({tag, "_done"}, 32'(stall), 32'd0);
        check_val({tag, "_reads"}, ack_count - reads0, nreads);
        if (idx < 0) begin
            check_val({tag, "_lat"}, cyc, last_ack_cyc + 1);
            model_install(lg, as, ppn, attr, glob);
        end
        check_val({tag, "_out"}, 32'(pack_obs()), 32'(pack_exp(ppn, attr)));
    endtask

    task automatic do_flush(input string tag, input logic [1:0] mode, input logic [19:0] lg,
                            input logic [ASID_BITS-1:0] as);
        int budget;
        @(negedge clk); #1;
        en_mmu     = 1'b0;
        logical    = lg;
        asid       = as;
        flush_mode = mode;
        flush_req  = 1'b1;
        budget = 0;
        #1;
        while (!flush_ack && budget < 20) begin
            @(negedge clk); #1;
            budget++;
        end
        check_val({tag, "_ack"}, 32'(flush_ack), 32'd1);
        flush_req = 1'b0;
        model_flush(mode, lg, as);
        @(negedge clk); #1;
        check_val({tag, "_pulse"}, 32'(flush_ack), 32'd0);
    endtask

    task automatic do_pass(input logic [19:0] lg);
        @(negedge clk); #1;
        en_mmu  = 1'b0;
        logical = lg;
        asid    = ASID_BITS'($urandom);
        #1;
        check_val("pass", {6'd0, stall, pack_obs()}, {6'd0, 1'b0, lg, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    endtask

    // ---------------- test sequence ----------------
    int          r0, budget, nr;
    logic [19:0] lg, wp;
    logic [4:0]  wa;
    logic        wg;

    initial begin
        rst = 1'b1; suspend = 1'b0; en_mmu = 1'b0; asid = '0; pdb_addr = 20'h10000;
        logical = '0; flush_req = 1'b0; flush_mode = 2'd0;
        for (int i = 0; i < LINE_NUM; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        mem[32'h10000004] = 32'h20000003;
        mem[32'h20000004] = 32'h30000017;
        mem[32'h20000008] = 32'h30001037;
        mem[32'h10000008] = 32'h00000000;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        en_mmu = 1'b1; logical = 20'h00401;
        #1;
        check_val("rst_ren", 32'(ren), 32'd0);
        check_val("rst_addr", addr, 32'd0);
        check_val("rst_flush_ack", 32'(flush_ack), 32'd0);
        check_val("rst_state", 32'(fsm_state), 32'd0);
        check_val("rst_cold_miss", 32'(stall), 32'd1);
        en_mmu = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;

        // cold miss, two-level walk
        rd_log.delete();
        do_access("cold", 20'h00401, 8'd3);
        check_val("cold_rd0", rd_log[0], 32'h10000004);
        check_val("cold_rd1", rd_log[1], 32'h20000004);
        check_val("cold_phys", 32'(physical), 32'h30000);
        check_val("cold_flags", {28'd0, page_fault, auth_user, auth_write, en_cache}, 32'b0100);

        // non-present directory entry
        do_access("pde_np", 20'h00800, 8'd3);
        check_val("pde_np_fault", 32'(page_fault), 32'd1);
        check_val("pde_np_ren", 32'(ren), 32'd0);

        // asid isolation and global lines
        r0 = ack_count;
        do_access("asid4", 20'h00401, 8'd4);
        check_val("asid4_walk", ack_count - r0, 32'd2);
        do_access("glob_a3", 20'h00402, 8'd3);
        r0 = ack_count;
        do_access("glob_a4", 20'h00402, 8'd4);
        check_val("glob_a4_hit", ack_count - r0, 32'd0);

        // flush by asid
        do_flush("fl_asid", 2'd1, 20'h00401, 8'd3);
        r0 = ack_count;
        do_access("fl_a4", 20'h00401, 8'd4);
        check_val("fl_a4_hit", ack_count - r0, 32'd0);
        r0 = ack_count;
        do_access("fl_glob", 20'h00402, 8'd4);
        check_val("fl_glob_hit", ack_count - r0, 32'd0);
        r0 = ack_count;
        do_access("fl_a3", 20'h00401, 8'd3);
        check_val("fl_a3_miss", ack_count - r0, 32'd2);

        // flush requested mid-walk waits for the install
        @(negedge clk); #1;
        lg = 20'h00403;
        model_walk(lg, wp, wa, wg, nr);
        ack_allow = 0;
        r0 = ack_count;
        logical = lg; asid = 8'd3; en_mmu = 1'b1;
        @(negedge clk); #1;
        check_val("mid_state", 32'(fsm_state), 32'd1);
        flush_mode = 2'd2; flush_req = 1'b1;
        @(negedge clk); #1;
        check_val("mid_noack", 32'(flush_ack), 32'd0);
        ack_allow = -1;
        budget = 0;
        while (!flush_ack && budget < 40) begin
            @(negedge clk); #1;
            budget++;
        end
        check_val("mid_ack", 32'(flush_ack), 32'd1);
        check_val("mid_reads", ack_count - r0, nr);
        flush_req = 1'b0; en_mmu = 1'b0;
        model_install(lg, 8'd3, wp, wa, wg);
        model_flush(2'd2, lg, 8'd3);
        @(negedge clk); #1;
        check_val("mid_pulse", 32'(flush_ack), 32'd0);
        do_access("mid_refetch", lg, 8'd3);

        // suspend during the PTE read
        @(negedge clk); #1;
        lg = 20'h00404;
        exp_q.delete();
        model_walk(lg, wp, wa, wg, nr);
        ack_allow = 1;
        logical = lg; asid = 8'd3; en_mmu = 1'b1;
        budget = 0;
        while (fsm_state != 2'd2 && budget < 20) begin
            @(negedge clk); #1;
            budget++;
        end
        check_val("susp_in_pte", 32'(fsm_state), 32'd2);
        @(negedge clk); #1;
        check_val("susp_ren_held", 32'(ren), 32'd1);
        suspend = 1'b1;
        @(negedge clk); #1;
        check_val("susp_ren", 32'(ren), 32'd0);
        check_val("susp_state", 32'(fsm_state), 32'd0);
        check_val("susp_pending", exp_q.size(), 32'd1);
        exp_q.delete();
        suspend = 1'b0; en_mmu = 1'b0; ack_allow = -1;
        rd_log.delete();
        r0 = ack_count;
        do_access("susp_rewalk", lg, 8'd3);
        check_val("susp_rewalk_pde", rd_log[0], 32'h10000004);
        check_val("susp_no_write", ack_count - r0, 32'd2);

        // fill LINE_NUM + 1 pages: the last install evicts line 0
        do_flush("fill_clr", 2'd0, 20'h0, 8'd5);
        for (int i = 0; i <= LINE_NUM; i++) do_access("fill", 20'h10000 + 20'(i), 8'd5);
        r0 = ack_count;
        do_access("evict_first", 20'h10000, 8'd5);
        check_val("evict_first_miss", 32'(ack_count != r0), 32'd1);
        r0 = ack_count;
        do_access("evict_keep", 20'h10002, 8'd5);
        check_val("evict_keep_hit", ack_count - r0, 32'd0);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            int r;
            r  = $urandom_range(0, 9);
            lg = {4'h2, 6'($urandom_range(0, 3)), 10'($urandom_range(0, 5))};
            if (r < 7)      do_access("rand", lg, ASID_BITS'($urandom_range(1, 3)));
            else if (r < 9) do_pass(20'($urandom));
            else            do_flush("rand_fl", 2'($urandom_range(0, 3)), lg,
                                     ASID_BITS'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
